irq_priority_ctrl: RTL
======================

Name: irq_priority_ctrl

Overview:
- Eight-source interrupt controller. Sequences presentation of requests through a fixed-priority encoder; the highest index wins.
- Latches rising edges on irq_in into a pending register and applies a mask.
- Presents one interrupt ID at a time to the CPU with an ack/EOI handshake.
- Sits between peripheral IRQ lines and the core's interrupt interface.

Parameters:
- N_SRC, 8, number of interrupt sources (fixed at 8 for this revision).
- ID_W, 3, width of irq_id, equal to $clog2(N_SRC).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  8  raw interrupt lines, already synchronous to clk; rising-edge sensitive.
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  8  new mask value; bit=1 disables the source.
- mask  output  8  current mask register.
- pending  output  8  current pending register.
- irq_out  output  1  interrupt request to the CPU.
- irq_id  output  3  index of the presented source; valid while irq_out=1.
- irq_ack  input  1  CPU accepts the presented interrupt.
- eoi  input  1  CPU signals end of interrupt service.
- in_service  output  1  high while an acknowledged interrupt is being serviced.

Behaviour:
- Reset (async, immediate): pending=0, mask=8'h00, irq_prev=0, state=IDLE, irq_out=0, irq_id=0, in_service=0.
- Edge detect: rise[i] = irq_in[i] & ~irq_prev[i]; irq_prev <= irq_in every cycle. A line that is high when reset is released counts as an edge on the first clock.
- Pending: pending[i] <= (pending[i] & ~clr[i]) | rise[i]. clr is the ack clear. Set wins over clear when both hit the same bit in the same cycle. Masked sources still latch pending.
- Mask: on mask_we, mask <= mask_wdata and takes effect the next cycle. Unmasking a pending source makes it eligible.
- eligible = pending & ~mask. The encoder picks the highest set index: bit7 gives ID 7, down to bit0 giving ID 0. valid=|eligible.
- FSM states are IDLE, PEND and SERVICE. All outputs are registered.
  - IDLE: if valid, go to PEND with irq_out<=1 and irq_id<=encoded ID.
  - PEND: irq_id is re-evaluated every cycle, so a higher-priority arrival replaces the presented ID before ack.
    - If valid drops (source masked), go to IDLE with irq_out<=0.
    - On irq_ack: clear pending[irq_id] (the currently registered ID), irq_out<=0, in_service<=1, go to SERVICE. irq_id holds its value.
  - SERVICE: no new presentation (no nesting); new edges still latch pending. On eoi: in_service<=0, go to IDLE.
- Latency: a rising edge sampled at clock edge k sets pending after edge k; irq_out rises after edge k+1. An ack sampled at edge m drops irq_out after edge m. After eoi, the next presentation appears 2 cycles later.
- irq_ack outside PEND is ignored. eoi outside SERVICE is ignored. Ack and eoi together in PEND: only the ack is honoured.
- Mask write and ack in the same cycle: the ack uses the registered irq_id, and the mask update applies next cycle.
- Reset mid-handshake: everything clears immediately and the FSM returns to IDLE. Lines held high re-trigger after reset release.

Decomposition:
- Shared package irq_pkg holds:
  - N_SRC and ID_W constants;
  - the state enum {IDLE, PEND, SERVICE};
  - the mask reset value MASK_RST=8'h00.
- Sub-module irq_prio_enc: purely combinational, 8-bit eligible in, 3-bit id plus valid out, highest index wins. It is instantiated once.

Test Plan:
- Reset, then pulse irq_in[3] for 1 cycle -> pending=8'h08 after 1 clk; irq_out=1, irq_id=3 after 2 clks; ack -> pending=0, in_service=1; eoi -> in_service=0, irq_out stays 0.
- Edges on bits 1 and 6 in the same cycle -> irq_id=6 first. After ack and eoi, irq_id=1 is presented 2 cycles later.
- In PEND with irq_id=2 and no ack, pulse irq_in[5] -> irq_id changes to 5. Ack -> pending=8'h04 remains, and it is presented after eoi.
- mask=8'hFF, pulse bits 0 and 7 -> pending=8'h81, irq_out stays 0. Write mask=8'h7F -> irq_out=1, irq_id=7 two cycles later.
- In PEND with ID 4, a new edge on bit 4 coincides with ack -> pending[4] stays 1. After eoi it is re-presented with irq_id=4.
- Assert rst while in SERVICE -> in_service, irq_out, pending and mask are all 0 immediately. Ack and eoi are ignored until a new edge arrives.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the eight-source priority interrupt controller.
package irq_pkg;
  localparam int N_SRC = 8;
  localparam int ID_W  = $clog2(N_SRC);
  localparam logic [N_SRC-1:0] MASK_RST = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the highest set index of eligible wins.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] eligible,
  output logic [ID_W-1:0]  id,
  output logic             valid
);
  always_comb begin
    id    = '0;
    valid = |eligible;
    // Ascending scan, so the last (highest) hit overwrites lower ones.
    for (int i = 0; i < N_SRC; i++)
      if (eligible[i]) id = ID_W'(i);
  end
endmodule

// File: rtl/irq_priority_ctrl.sv
// Edge-latched, maskable interrupt controller presenting one ID at a time
// with an ack/EOI handshake; no nesting while an interrupt is in service.
module irq_priority_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             irq_out,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             in_service
);
  irq_state_e       state, state_nxt;
  logic [N_SRC-1:0] irq_prev, rise, clr, eligible;
  logic [ID_W-1:0]  enc_id, irq_id_nxt;
  logic             enc_vld, irq_out_nxt, in_service_nxt;

  assign rise     = irq_in & ~irq_prev;
  assign eligible = pending & ~mask;

  irq_prio_enc u_enc (
    .eligible (eligible),
    .id       (enc_id),
    .valid    (enc_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev <= '0;
      mask     <= MASK_RST;
    end else begin
      irq_prev <= irq_in;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Per-source pending bit; a fresh edge beats a same-cycle ack clear.
  for (genvar g = 0; g < N_SRC; g++) begin : g_pend
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pending[g] <= 1'b0;
      else     pending[g] <= (pending[g] & ~clr[g]) | rise[g];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      irq_out    <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nxt;
      irq_out    <= irq_out_nxt;
      irq_id     <= irq_id_nxt;
      in_service <= in_service_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    irq_out_nxt    = irq_out;
    irq_id_nxt     = irq_id;
    in_service_nxt = in_service;
    clr            = '0;
    case (state)
      IDLE: begin
        if (enc_vld) begin
          state_nxt   = PEND;
          irq_out_nxt = 1'b1;
          irq_id_nxt  = enc_id;
        end
      end
      PEND: begin
        // Ack targets the ID the CPU actually saw, i.e. the registered one.
        if (irq_ack) begin
          clr[irq_id]    = 1'b1;
          irq_out_nxt    = 1'b0;
          in_service_nxt = 1'b1;
          state_nxt      = SERVICE;
        end else if (!enc_vld) begin
          irq_out_nxt = 1'b0;
          state_nxt   = IDLE;
        end else begin
          irq_id_nxt = enc_id;
        end
      end
      SERVICE: begin
        if (eoi) begin
          in_service_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt      = IDLE;
        irq_out_nxt    = 1'b0;
        in_service_nxt = 1'b0;
      end
    endcase
  end
endmodule
